// File: rtl/mem_arbiter_rr.sv
// N-channel SDRAM command-port arbiter with fixed-priority or round-robin selection,
// a per-grant ack budget (burst lock) and registered read-return routing by source tag.
module mem_arbiter_rr #(
    parameter int N    = 4,
    parameter int AN   = 24,
    parameter int DN   = 16,
    parameter int IDN  = 2,
    parameter int SN   = $clog2(N),
    parameter int MODE = 1,
    parameter int LOCK = 8
) (
    input  logic             clkSYS,
    input  logic             n_reset,
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     wr,
    input  logic [N*AN-1:0]  addr,
    input  logic [N*DN-1:0]  data,
    input  logic [N*IDN-1:0] id,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     valid,
    output logic [DN-1:0]    rdata,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [AN-1:0]    mem_addr,
    output logic [DN-1:0]    mem_data,
    output logic [IDN-1:0]   mem_id,
    output logic [SN-1:0]    mem_src,
    input  logic             mem_ack,
    input  logic             mem_valid,
    input  logic [DN-1:0]    mem_rdata,
    input  logic [SN-1:0]    mem_rsrc
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SN-1:0]   grant_q, grant_d;
    logic [SN-1:0]   ptr_q, ptr_d;
    logic [7:0]      cnt_q, cnt_d;
    logic [N-1:0]    valid_q, valid_d;
    logic [DN-1:0]   rdata_q, rdata_d;

    logic [SN-1:0]   pick_s;
    logic [SN-1:0]   sel_s;
    logic [SN-1:0]   next_ptr_s;
    logic [SN:0]     idx_s;
    logic            found_s;
    logic            cur_req_s;
    logic            ack_hit_s;

    // Candidate search: from channel 0 (fixed) or from the rr pointer with wrap (round robin).
    always_comb begin
        pick_s  = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int j = 0; j < N; j++) begin
            if (MODE == 0) begin
                idx_s = (SN+1)'(j);
            end else begin
                idx_s = {1'b0, ptr_q} + (SN+1)'(j);
                idx_s = (idx_s >= (SN+1)'(N)) ? (idx_s - (SN+1)'(N)) : idx_s;
            end
            if (!found_s && req[idx_s[SN-1:0]]) begin
                found_s = 1'b1;
                pick_s  = idx_s[SN-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    // Command-path mux: the granted channel while BUSY, channel 0 while IDLE.
    always_comb begin
        sel_s    = (state_q == BUSY) ? grant_q : '0;
        mem_wr   = wr[0];
        mem_addr = addr[AN-1:0];
        mem_data = data[DN-1:0];
        mem_id   = id[IDN-1:0];
        for (int i = 1; i < N; i++) begin
            mem_wr   = (sel_s == SN'(i)) ? wr[i]              : mem_wr;
            mem_addr = (sel_s == SN'(i)) ? addr[i*AN +: AN]   : mem_addr;
            mem_data = (sel_s == SN'(i)) ? data[i*DN +: DN]   : mem_data;
            mem_id   = (sel_s == SN'(i)) ? id[i*IDN +: IDN]   : mem_id;
        end
        mem_src = sel_s;
    end

    // Grant-side strobes; all zero whenever no grant is held, including under reset.
    always_comb begin
        cur_req_s  = req[grant_q];
        ack_hit_s  = (state_q == BUSY) & mem_ack & cur_req_s;
        mem_req    = (state_q == BUSY) & cur_req_s;
        ack        = ack_hit_s ? (N'(1) << grant_q) : '0;
        next_ptr_s = (grant_q == SN'(N - 1)) ? '0 : (grant_q + SN'(1));
    end

    // Grant FSM next state: acquire on any request, release on request drop or exhausted lock budget.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    state_d = BUSY;
                    grant_d = pick_s;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (!cur_req_s) begin
                    state_d = IDLE;
                    ptr_d   = next_ptr_s;
                end else if (ack_hit_s) begin
                    if (cnt_q == 8'(LOCK - 1)) begin
                        state_d = IDLE;
                        ptr_d   = next_ptr_s;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end else begin
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Grant FSM state register.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Read-return decode; tags at or above N match no channel and are dropped.
    always_comb begin
        valid_d = '0;
        for (int i = 0; i < N; i++) begin
            valid_d[i] = mem_valid & (mem_rsrc == SN'(i));
        end
        rdata_d = mem_valid ? mem_rdata : rdata_q;
    end

    // Read-return register, independent of the grant state.
    always_ff @(posedge clkSYS or negedge n_reset) begin
        if (!n_reset) begin
            valid_q <= '0;
            rdata_q <= '0;
        end else begin
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    assign valid = valid_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Bench for mem_arbiter_rr: four configurations share one stimulus and are each checked
// every cycle against a behavioural grant/read-return model, plus directed literal checks.
module tb_mem_arbiter_rr;

    logic          clk;
    logic          rst_n;
    logic [7:0]    req_s;
    logic [7:0]    wr_s;
    logic [191:0]  addr_s;
    logic [127:0]  data_s;
    logic [15:0]   id_s;
    logic          mem_ack_s;
    logic          mem_valid_s;
    logic [15:0]   mem_rdata_s;
    logic [2:0]    mem_rsrc_s;

    logic [7:0]    dut_ack   [4];
    logic [7:0]    dut_valid [4];
    logic [15:0]   dut_rdata [4];
    logic          dut_mreq  [4];
    logic          dut_mwr   [4];
    logic [23:0]   dut_maddr [4];
    logic [15:0]   dut_mdata [4];
    logic [1:0]    dut_mid   [4];
    logic [2:0]    dut_msrc  [4];

    int tests = 0;
    int fails = 0;

    // Instance 0: N4 RR LOCK8, 1: N4 fixed LOCK4, 2: N4 RR LOCK1, 3: N5 RR LOCK2.
    for (genvar k = 0; k < 4; k++) begin : g_dut
        localparam int NN  = (k == 3) ? 5 : 4;
        localparam int SNN = $clog2(NN);
        localparam int MD  = (k == 1) ? 0 : 1;
        localparam int LK  = (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 1 : 2;
        logic [NN-1:0]  ack_w, valid_w;
        logic [15:0]    rdata_w, mdata_w;
        logic           mreq_w, mwr_w;
        logic [23:0]    maddr_w;
        logic [1:0]     mid_w;
        logic [SNN-1:0] msrc_w;
        mem_arbiter_rr #(.N(NN), .AN(24), .DN(16), .IDN(2), .SN(SNN), .MODE(MD), .LOCK(LK)) u_dut (
            .clkSYS    (clk),
            .n_reset   (rst_n),
            .req       (req_s[NN-1:0]),
            .wr        (wr_s[NN-1:0]),
            .addr      (addr_s[NN*24-1:0]),
            .data      (data_s[NN*16-1:0]),
            .id        (id_s[NN*2-1:0]),
            .ack       (ack_w),
            .valid     (valid_w),
            .rdata     (rdata_w),
            .mem_req   (mreq_w),
            .mem_wr    (mwr_w),
            .mem_addr  (maddr_w),
            .mem_data  (mdata_w),
            .mem_id    (mid_w),
            .mem_src   (msrc_w),
            .mem_ack   (mem_ack_s),
            .mem_valid (mem_valid_s),
            .mem_rdata (mem_rdata_s),
            .mem_rsrc  (mem_rsrc_s[SNN-1:0])
        );
        assign dut_ack[k]   = 8'(ack_w);
        assign dut_valid[k] = 8'(valid_w);
        assign dut_rdata[k] = rdata_w;
        assign dut_mreq[k]  = mreq_w;
        assign dut_mwr[k]   = mwr_w;
        assign dut_maddr[k] = maddr_w;
        assign dut_mdata[k] = mdata_w;
        assign dut_mid[k]   = mid_w;
        assign dut_msrc[k]  = 3'(msrc_w);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nk(input int k);
        return (k == 3) ? 5 : 4;
    endfunction
    function automatic int modek(input int k);
        return (k == 1) ? 0 : 1;
    endfunction
    function automatic int lockk(input int k);
        return (k == 0) ? 8 : (k == 1) ? 4 : (k == 2) ? 1 : 2;
    endfunction
    function automatic int tagk(input int k);
        return (k == 3) ? int'(mem_rsrc_s) : int'(mem_rsrc_s[1:0]);
    endfunction

    // Model state: who holds the grant, acks taken so far, where round robin resumes.
    int          m_busy [4];
    int          m_g    [4];
    int          m_ptr  [4];
    int          m_cnt  [4];
    logic [7:0]  m_valid[4];
    logic [15:0] m_rdata[4];

    function automatic int pick(input int k);
        int idx;
        for (int j = 0; j < nk(k); j++) begin
            idx = (modek(k) == 0) ? j : (m_ptr[k] + j) % nk(k);
            if (req_s[idx]) return idx;
        end
        return 0;
    endfunction

    function automatic logic [7:0] chmask(input int k);
        return (k == 3) ? 8'h1F : 8'h0F;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                m_busy[k]  <= 0;
                m_g[k]     <= 0;
                m_ptr[k]   <= 0;
                m_cnt[k]   <= 0;
                m_valid[k] <= 8'h00;
                m_rdata[k] <= 16'h0000;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (m_busy[k] == 0) begin
                    if ((req_s & chmask(k)) != 8'h00) begin
                        m_busy[k] <= 1;
                        m_g[k]    <= pick(k);
                        m_cnt[k]  <= 0;
                    end
                end else if (!req_s[m_g[k]]) begin
                    m_busy[k] <= 0;
                    m_ptr[k]  <= (m_g[k] + 1) % nk(k);
                end else if (mem_ack_s) begin
                    if (m_cnt[k] + 1 == lockk(k)) begin
                        m_busy[k] <= 0;
                        m_ptr[k]  <= (m_g[k] + 1) % nk(k);
                    end else begin
                        m_cnt[k] <= m_cnt[k] + 1;
                    end
                end
                m_valid[k] <= (mem_valid_s && tagk(k) < nk(k)) ? (8'd1 << tagk(k)) : 8'd0;
                if (mem_valid_s) m_rdata[k] <= mem_rdata_s;
            end
        end
    end

    task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s inst%0d actual=%0h required=%0h", nm, k, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int k = 0; k < 4; k++) begin
            chk("mem_req", k, 64'(dut_mreq[k]), 64'((m_busy[k] != 0) && req_s[m_g[k]]));
            chk("ack", k, 64'(dut_ack[k]),
                ((m_busy[k] != 0) && mem_ack_s && req_s[m_g[k]]) ? (64'd1 << m_g[k]) : 64'd0);
            if (m_busy[k] != 0) begin
                chk("mem_src",  k, 64'(dut_msrc[k]),  64'(m_g[k]));
                chk("mem_addr", k, 64'(dut_maddr[k]), 64'(addr_s[m_g[k]*24 +: 24]));
                chk("mem_data", k, 64'(dut_mdata[k]), 64'(data_s[m_g[k]*16 +: 16]));
                chk("mem_wr",   k, 64'(dut_mwr[k]),   64'(wr_s[m_g[k]]));
                chk("mem_id",   k, 64'(dut_mid[k]),   64'(id_s[m_g[k]*2 +: 2]));
            end
            chk("valid", k, 64'(dut_valid[k]), 64'(m_valid[k]));
            chk("rdata", k, 64'(dut_rdata[k]), 64'(m_rdata[k]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp8;

    initial begin
        rst_n = 1'b0; req_s = 8'h0F; wr_s = 8'h00; addr_s = '0; data_s = '0; id_s = 16'h0000;
        mem_ack_s = 1'b1; mem_valid_s = 1'b0; mem_rdata_s = 16'h0000; mem_rsrc_s = 3'd0;
        cyc(); cyc();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            chk("rst_mem_req", k, 64'(dut_mreq[k]), 64'd0);
            chk("rst_ack",     k, 64'(dut_ack[k]),  64'd0);
            chk("rst_valid",   k, 64'(dut_valid[k]), 64'd0);
            chk("rst_rdata",   k, 64'(dut_rdata[k]), 64'd0);
        end
        req_s = 8'h00;
        cyc(); rst_n = 1'b1;
        cyc();

        // Round robin, LOCK 8, channels 0 and 2 requesting, mem_ack tied high.
        cyc(); req_s = 8'h05; mem_ack_s = 1'b1;
        @(negedge clk);
        chk("rr8_first_cycle_idle", 0, 64'(dut_mreq[0]), 64'd0);
        for (int c = 1; c <= 35; c++) begin
            cyc();
            @(negedge clk);
            case (c % 18)
                1, 2, 3, 4, 5, 6, 7, 8:          exp8 = 8'h01;
                10, 11, 12, 13, 14, 15, 16, 17:  exp8 = 8'h04;
                default:                         exp8 = 8'h00;
            endcase
            chk("rr8_ack", 0, 64'(dut_ack[0]), 64'(exp8));
        end

        // Fixed priority, LOCK 4, all channels; req0 dropped during a ch0 grant.
        cyc(); req_s = 8'h00; cyc();
        cyc(); req_s = 8'h0F;
        @(negedge clk);
        for (int c = 1; c <= 16; c++) begin
            cyc();
            if (c == 11) req_s = 8'h0E;
            @(negedge clk);
            if (c <= 10)      exp8 = (c % 5 == 0) ? 8'h00 : 8'h01;
            else if (c <= 12) exp8 = 8'h00;
            else              exp8 = 8'h02;
            chk("fixed_ack", 1, 64'(dut_ack[1]), 64'(exp8));
        end

        // Single write request on channel 3, accepted three cycles later.
        cyc(); req_s = 8'h00; mem_ack_s = 1'b0; cyc(); cyc();
        addr_s[3*24 +: 24] = 24'h123456; data_s[3*16 +: 16] = 16'hBEEF;
        wr_s = 8'h08; id_s[7:6] = 2'b10;
        cyc(); req_s = 8'h08;
        @(negedge clk);
        chk("single_latency", 0, 64'(dut_mreq[0]), 64'd0);
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 3) mem_ack_s = 1'b1;
            if (c == 4) begin mem_ack_s = 1'b0; req_s = 8'h00; end
            @(negedge clk);
            if (c <= 3) begin
                chk("single_mem_req",  0, 64'(dut_mreq[0]),  64'd1);
                chk("single_mem_addr", 0, 64'(dut_maddr[0]), 64'h123456);
                chk("single_mem_data", 0, 64'(dut_mdata[0]), 64'hBEEF);
                chk("single_mem_src",  0, 64'(dut_msrc[0]),  64'd3);
                chk("single_mem_wr",   0, 64'(dut_mwr[0]),   64'd1);
            end
            chk("single_ack", 0, 64'(dut_ack[0]), (c == 3) ? 64'h08 : 64'h00);
        end

        // Read return by tag while channel 1 holds an unacked grant.
        cyc(); req_s = 8'h02;
        cyc(); mem_valid_s = 1'b1; mem_rsrc_s = 3'd2; mem_rdata_s = 16'h0001;
        cyc(); mem_rsrc_s = 3'd0; mem_rdata_s = 16'h0002;
        @(negedge clk);
        chk("rd_valid_t2", 0, 64'(dut_valid[0]), 64'h04);
        chk("rd_data_t2",  0, 64'(dut_rdata[0]), 64'h0001);
        cyc(); mem_rsrc_s = 3'd1; mem_rdata_s = 16'h0003;
        @(negedge clk);
        chk("rd_valid_t0", 0, 64'(dut_valid[0]), 64'h01);
        chk("rd_data_t0",  0, 64'(dut_rdata[0]), 64'h0002);
        cyc(); mem_rsrc_s = 3'd5; mem_rdata_s = 16'h0004;
        @(negedge clk);
        chk("rd_valid_t1", 0, 64'(dut_valid[0]), 64'h02);
        chk("rd_data_t1",  0, 64'(dut_rdata[0]), 64'h0003);
        chk("rd_grant_held", 0, 64'(dut_mreq[0]), 64'd1);
        cyc(); mem_valid_s = 1'b0;
        @(negedge clk);
        chk("rd_valid_t5_dropped", 3, 64'(dut_valid[3]), 64'h00);
        chk("rd_data_t5",          3, 64'(dut_rdata[3]), 64'h0004);
        cyc();
        @(negedge clk);
        chk("rd_data_hold", 3, 64'(dut_rdata[3]), 64'h0004);

        // Reset asserted during the fourth ack of a channel 1 burst.
        cyc(); mem_ack_s = 1'b1;
        cyc();
        cyc(); mem_valid_s = 1'b1; mem_rsrc_s = 3'd1; mem_rdata_s = 16'h00AA;
        cyc(); mem_valid_s = 1'b0;
        @(negedge clk);
        chk("burst_ack4",   0, 64'(dut_ack[0]),   64'h02);
        chk("burst_valid",  0, 64'(dut_valid[0]), 64'h02);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 0, 64'(dut_mreq[0]),  64'd0);
        chk("rst_mid_ack",     0, 64'(dut_ack[0]),   64'd0);
        chk("rst_mid_valid",   0, 64'(dut_valid[0]), 64'd0);
        chk("rst_mid_rdata",   0, 64'(dut_rdata[0]), 64'd0);
        cyc(); cyc(); rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", 0, 64'(dut_mreq[0]), 64'd0);
        for (int c = 1; c <= 9; c++) begin
            cyc();
            @(negedge clk);
            chk("post_rst_fresh_lock", 0, 64'(dut_ack[0]), (c <= 8) ? 64'h02 : 64'h00);
        end

        // Round robin, LOCK 1, all channels requesting from a fresh pointer.
        cyc(); rst_n = 1'b0; req_s = 8'h00;
        cyc(); rst_n = 1'b1;
        cyc(); req_s = 8'h1F; mem_ack_s = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 12; c++) begin
            cyc();
            @(negedge clk);
            exp8 = (c % 2 == 1) ? (8'd1 << (((c - 1) / 2) % 4)) : 8'h00;
            chk("rr1_ack", 2, 64'(dut_ack[2]), 64'(exp8));
        end

        // Mixed traffic; the per-cycle model comparison does the checking.
        for (int c = 0; c < 400; c++) begin
            cyc();
            if (c % 3 == 0) req_s = 8'($urandom);
            wr_s        = 8'($urandom);
            mem_ack_s   = 1'($urandom);
            mem_valid_s = 1'($urandom);
            mem_rsrc_s  = 3'($urandom);
            mem_rdata_s = 16'($urandom);
            id_s        = 16'($urandom);
            for (int i = 0; i < 8; i++) begin
                addr_s[i*24 +: 24] = 24'($urandom);
                data_s[i*16 +: 16] = 16'($urandom);
            end
        end
        cyc();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
